vga_stream_out: RTL and testbench
=================================

// Module: vga_stream_out
// PURPOSE
//  Parametrised VGA output stage: generates H/V timing, consumes an AXI4-Stream pixel
//  stream (tuser=SOF, tlast=EOL) and drives registered sync/RGB/DE. Locks to the stream
//  on SOF, and detects underflow/framing errors with automatic resync.
//  Sits between the frame buffer/DMA reader and the board DAC/pins.
// PARAMETERS
//  COLOR_W    4    bits per colour channel
//  H_RES      640  active pixels per line
//  H_FP       16   horizontal front porch (clk)
//  H_SYNC     96   hsync pulse width (clk)
//  H_BP       48   horizontal back porch (clk)
//  V_RES      480  active lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines)
//  HSYNC_POL  0    hsync active level (0=active-low)
//  VSYNC_POL  0    vsync active level
// PORTS
//  aclk        in   1          pixel clock
//  aresetn     in   1          async reset, active-low
//  pix_tvalid  in   1          stream valid
//  pix_tready  out  1          stream ready
//  pix_tdata   in   3*COLOR_W  {b,g,r}, r in LSBs
//  pix_tlast   in   1          last pixel of line
//  pix_tuser   in   1          first pixel of frame
//  hsync       out  1          horizontal sync, polarity HSYNC_POL
//  vsync       out  1          vertical sync, polarity VSYNC_POL
//  r, g, b     out  COLOR_W    colour; 0 outside active area or when not locked
//  de          out  1          data enable (active pixel shown)
//  sof         out  1          1-cycle pulse with first active pixel of each frame
//  underflow   out  1          1-cycle pulse: active pixel with no valid beat
//  frame_err   out  1          1-cycle pulse: tlast/tuser misplaced
// BEHAVIOUR
//  - Reset is aresetn, asynchronous, active-low; clock is aclk.
//  - h_cnt 0..H_TOTAL-1 (H_TOTAL=H_RES+H_FP+H_SYNC+H_BP), order ACTIVE,FP,SYNC,BP;
//    v_cnt advances when h_cnt wraps. Reset: h_cnt=0, v_cnt=V_RES (first line of V FP).
//  - active = h_cnt<H_RES && v_cnt<V_RES. Sync asserted for count in [RES+FP, RES+FP+SYNC).
//  - All outputs registered, 1 clk latency from counters. Reset: hsync=!HSYNC_POL,
//    vsync=!VSYNC_POL, rgb=0, de=0, sof=0, underflow=0, frame_err=0.
//  - Lock FSM, reset state SEARCH:
//    SEARCH: tready=1 while head beat lacks tuser (beats dropped). When tvalid&&tuser:
//      tready=0, hold beat, go WAIT.
//    WAIT: tready=0 until h_cnt==0&&v_cnt==0, then LOCKED (that beat is pixel 0).
//    LOCKED: tready=active. Beat consumed on tvalid&&tready; drives rgb, de=1.
//      sof=1 on the pixel 0 beat.
//  - LOCKED errors (pulse, then state SEARCH, rgb=0 for rest of frame, de still=active):
//    underflow: active && !tvalid.
//    frame_err: tlast!=(h_cnt==H_RES-1), or tuser!=(h_cnt==0&&v_cnt==0), on a consumed beat.
//    underflow and frame_err on the same pixel cannot occur (no beat consumed).
//  - Outside active area in LOCKED: tready=0, rgb=0, de=0. Timing never stalls on stream.
//  - Reset mid-frame: counters/FSM reinitialise; any held beat abandoned, no recovery.
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined: extra input port test_pattern (1 bit). When 1:
//    FSM forced to SEARCH with tready=0; active pixels show 8 equal-width vertical bars
//    (bar k = h_cnt*8/H_RES; r=bit0,g=bit1,b=bit2 of k, channel all-ones or 0);
//    de/sof/syncs as normal, underflow/frame_err=0. On 1->0, normal SEARCH resumes.
//  - Not defined: no test_pattern port, no pattern logic.
// TESTING
//  Params: COLOR_W=4,H_RES=8,H_FP=2,H_SYNC=3,H_BP=3 (H_TOTAL=16),
//  V_RES=4,V_FP=1,V_SYNC=2,V_BP=1 (V_TOTAL=8), HSYNC_POL=VSYNC_POL=0.
//  1 Reset, no stream -> hsync low 3 of every 16 clks at h_cnt 10..12 (+1 latency); vsync
//    low lines 5..6; de=0, rgb=0, pix_tready=1 (SEARCH).
//  2 Valid frame, tdata=pixel index, tuser on pix0, tlast at col 7 -> sof once/frame,
//    de 8 clks/line, rgb matches tdata at 1 clk latency, no error pulses over 3 frames.
//  3 Stream starts mid-frame w/o tuser -> beats dropped (tready=1), lock at next
//    h=0,v=0, first displayed pixel = tuser beat's data.
//  4 tvalid low at line1 col3 -> underflow pulse 1 clk, rgb=0 to end of frame,
//    relock on next frame's SOF, pixels correct thereafter.
//  5 tlast at col 5 -> frame_err pulse, SEARCH; tuser at line 2 col 0 -> frame_err.
//  6 VGA_TEST_PATTERN_EN, test_pattern=1 -> cols 0..7 show r/g/b = 000,F00,0F0,FF0,00F,
//    F0F,0FF,FFF ({r,g,b} per col), pix_tready=0, errors=0.

Source files
------------

// File: rtl/vga_stream_out.sv
// VGA output stage: H/V timing, AXI4-Stream pixel lock (tuser=SOF, tlast=EOL), registered sync/RGB/DE.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_pattern input that shows 8 colour bars.
module vga_stream_out #(
    parameter int   COLOR_W   = 4,
    parameter int   H_RES     = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_RES     = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   pix_tvalid,
    output logic                   pix_tready,
    input  logic [3*COLOR_W-1:0]   pix_tdata,
    input  logic                   pix_tlast,
    input  logic                   pix_tuser,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   test_pattern,
`endif
    output logic                   hsync,
    output logic                   vsync,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   de,
    output logic                   sof,
    output logic                   underflow,
    output logic                   frame_err
);

    // state     | meaning
    // SEARCH    | dropping beats until one carries tuser
    // WAIT      | SOF beat held, waiting for h_cnt==0 && v_cnt==0
    // LOCKED    | one beat consumed per active pixel
    typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_LOCKED} state_t;

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [31:0] H_ACT  = 32'(H_RES);
    localparam logic [31:0] H_SS   = 32'(H_RES + H_FP);
    localparam logic [31:0] H_SE   = 32'(H_RES + H_FP + H_SYNC);
    localparam logic [31:0] H_LAST = 32'(H_TOTAL - 1);
    localparam logic [31:0] H_EOL  = 32'(H_RES - 1);
    localparam logic [31:0] V_ACT  = 32'(V_RES);
    localparam logic [31:0] V_SS   = 32'(V_RES + V_FP);
    localparam logic [31:0] V_SE   = 32'(V_RES + V_FP + V_SYNC);
    localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    state_t        state;
    logic          blank;

    logic [31:0] h_ext, v_ext;
    logic        h_wrap, v_wrap, frame_wrap, frame_start, active, last_col;
    logic        in_hsync, in_vsync, beat_err;

    assign h_ext       = 32'(h_cnt);
    assign v_ext       = 32'(v_cnt);
    assign h_wrap      = (h_ext == H_LAST);
    assign v_wrap      = (v_ext == V_LAST);
    assign frame_wrap  = h_wrap && v_wrap;
    assign frame_start = (h_ext == 32'd0) && (v_ext == 32'd0);
    assign active      = (h_ext < H_ACT) && (v_ext < V_ACT);
    assign last_col    = (h_ext == H_EOL);
    assign in_hsync    = (h_ext >= H_SS) && (h_ext < H_SE);
    assign in_vsync    = (v_ext >= V_SS) && (v_ext < V_SE);
    assign beat_err    = (pix_tlast != last_col) || (pix_tuser != frame_start);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar = 3'((h_ext * 32'd8) / H_ACT);
`endif

    always_comb begin
        pix_tready = 1'b0;
        case (state)
            ST_SEARCH: pix_tready = !(pix_tvalid && pix_tuser);
            ST_LOCKED: pix_tready = active;
            default:   pix_tready = 1'b0;
        endcase
`ifdef VGA_TEST_PATTERN_EN
        if (test_pattern) pix_tready = 1'b0;
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            h_cnt     <= '0;
            v_cnt     <= VW'(V_RES);
            state     <= ST_SEARCH;
            blank     <= 1'b0;
            hsync     <= ~HSYNC_POL;
            vsync     <= ~VSYNC_POL;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            de        <= 1'b0;
            sof       <= 1'b0;
            underflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
            hsync     <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync     <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            sof       <= 1'b0;
            underflow <= 1'b0;
            frame_err <= 1'b0;
            // after an error the active area stays marked but black until the frame ends
            de        <= active && blank;
            if (frame_wrap) blank <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            if (test_pattern) begin
                state <= ST_SEARCH;
                blank <= 1'b0;
                de    <= active;
                sof   <= active && frame_start;
                if (active) begin
                    r <= {COLOR_W{bar[0]}};
                    g <= {COLOR_W{bar[1]}};
                    b <= {COLOR_W{bar[2]}};
                end
            end else
`endif
            case (state)
                ST_SEARCH: begin
                    if (pix_tvalid && pix_tuser) state <= frame_wrap ? ST_LOCKED : ST_WAIT;
                end
                ST_WAIT: begin
                    if (frame_wrap) state <= ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (active) begin
                        de <= 1'b1;
                        if (!pix_tvalid) begin
                            underflow <= 1'b1;
                            state     <= ST_SEARCH;
                            blank     <= 1'b1;
                        end else if (beat_err) begin
                            frame_err <= 1'b1;
                            state     <= ST_SEARCH;
                            blank     <= 1'b1;
                        end else begin
                            r   <= pix_tdata[COLOR_W-1:0];
                            g   <= pix_tdata[2*COLOR_W-1:COLOR_W];
                            b   <= pix_tdata[3*COLOR_W-1:2*COLOR_W];
                            sof <= frame_start;
                        end
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// Randomized bench for vga_stream_out on a 16x8 raster against a frame-level reference model.
// Builds with or without VGA_TEST_PATTERN_EN; the bar phase runs only when the macro is defined.
module tb_vga_stream_out;

    localparam int CW = 4;
    localparam int HR = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VR = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HR + HFP + HS + HBP;
    localparam int VT = VR + VFP + VS + VBP;
    localparam int NPIX = HR * VR;

    typedef struct {
        logic [3*CW-1:0] data;
        logic            last;
        logic            user;
        logic            gap;
    } beat_t;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            pix_tvalid = 1'b0;
    logic            pix_tready;
    logic [3*CW-1:0] pix_tdata = '0;
    logic            pix_tlast = 1'b0;
    logic            pix_tuser = 1'b0;
    logic            tp = 1'b0;
    logic            hsync, vsync, de, sof, underflow, frame_err;
    logic [CW-1:0]   r, g, b;

    vga_stream_out #(
        .COLOR_W(CW), .H_RES(HR), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_RES(VR), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .pix_tvalid(pix_tvalid), .pix_tready(pix_tready), .pix_tdata(pix_tdata),
        .pix_tlast(pix_tlast), .pix_tuser(pix_tuser),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(tp),
`endif
        .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
        .de(de), .sof(sof), .underflow(underflow), .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    int    n_chk = 0;
    int    n_bad = 0;
    int    t = 0;
    int    start_at = 0;
    int    frame_no = 0;
    bit    seeded = 0;
    bit    locked = 0, holding = 0, blank = 0;
    beat_t q[$];

    logic            e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_sof = 1'b0, e_uf = 1'b0, e_fe = 1'b0;
    logic [3*CW-1:0] e_rgb = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic push_garbage(input int n);
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            bt.data = 12'($urandom);
            bt.last = 1'($urandom);
            bt.user = 1'b0;
            bt.gap  = 1'b0;
            q.push_back(bt);
        end
    endtask

    // kind: 0 clean, 1 valid gap before pixel p, 2 extra tlast at pixel p,
    //       3 extra tuser at pixel p, 4 no tuser on pixel 0
    task automatic push_frame(input int kind, input int p);
        beat_t bt;
        for (int i = 0; i < NPIX; i++) begin
            bt.data = 12'($urandom);
            bt.last = (i % HR == HR - 1) || (kind == 2 && i == p);
            bt.user = (i == 0 && kind != 4) || (kind == 3 && i == p);
            bt.gap  = (kind == 1 && i == p);
            q.push_back(bt);
        end
    endtask

    task automatic refill();
        int sel;
        if (t < start_at || q.size() >= 40) return;
        if (!seeded) begin
            push_garbage(13);
            seeded = 1;
        end
        case (frame_no)
            3:       push_frame(1, 1 * HR + 3);
            5:       push_frame(2, 5);
            7:       push_frame(3, 2 * HR);
            0, 1, 2, 4, 6, 8: push_frame(0, 0);
            default: begin
                sel = $urandom_range(0, 9);
                case (sel)
                    5: push_frame(1, $urandom_range(1, NPIX - 1));
                    6: push_frame(2, $urandom_range(0, VR - 1) * HR + $urandom_range(0, HR - 2));
                    7: push_frame(3, $urandom_range(1, NPIX - 1));
                    8: push_frame(4, 0);
                    9: begin push_garbage($urandom_range(1, 6)); push_frame(0, 0); end
                    default: push_frame(0, 0);
                endcase
            end
        endcase
        frame_no++;
    endtask

    // reference: raster position from elapsed cycles, lock/blank tracked per frame
    task automatic model_step(input logic tv, input logic [3*CW-1:0] td, input logic tl,
                              input logic tu, output logic e_tr);
        int h, v, k;
        bit fs, act;
        h   = t % HT;
        v   = (t / HT + VR) % VT;
        fs  = (h == 0) && (v == 0);
        act = (h < HR) && (v < VR);
        if (fs) begin
            blank = 0;
            if (holding) begin
                locked  = 1;
                holding = 0;
            end
        end
        e_hs  = !((h >= HR + HFP) && (h < HR + HFP + HS));
        e_vs  = !((v >= VR + VFP) && (v < VR + VFP + VS));
        e_rgb = '0;
        e_de  = 1'b0;
        e_sof = 1'b0;
        e_uf  = 1'b0;
        e_fe  = 1'b0;
        if (tp) begin
            locked  = 0;
            holding = 0;
            blank   = 0;
            e_tr    = 1'b0;
            if (act) begin
                k     = h * 8 / HR;
                e_de  = 1'b1;
                e_sof = fs;
                e_rgb = {{CW{k[2]}}, {CW{k[1]}}, {CW{k[0]}}};
            end
        end else if (locked) begin
            e_tr = act;
            if (act) begin
                e_de = 1'b1;
                if (!tv) begin
                    e_uf   = 1'b1;
                    locked = 0;
                    blank  = 1;
                end else if (tl != (h == HR - 1) || tu != fs) begin
                    e_fe   = 1'b1;
                    locked = 0;
                    blank  = 1;
                end else begin
                    e_rgb = td;
                    e_sof = fs;
                end
            end
        end else begin
            e_tr = holding ? 1'b0 : !(tv && tu);
            e_de = act && blank;
            if (!holding && tv && tu) holding = 1;
        end
    endtask

    task automatic check_outputs();
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("rgb", {b, g, r}, e_rgb);
        check("de", de, e_de);
        check("sof", sof, e_sof);
        check("underflow", underflow, e_uf);
        check("frame_err", frame_err, e_fe);
    endtask

    task automatic run_cycles(input int n);
        logic  tv, tl, tu, e_tr;
        logic [3*CW-1:0] td;
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            refill();
            if (q.size() > 0 && !q[0].gap) begin
                tv = 1'b1; td = q[0].data; tl = q[0].last; tu = q[0].user;
            end else begin
                tv = 1'b0; td = 12'($urandom); tl = 1'($urandom); tu = 1'($urandom);
            end
            pix_tvalid = tv;
            pix_tdata  = td;
            pix_tlast  = tl;
            pix_tuser  = tu;
            #1;
            model_step(tv, td, tl, tu, e_tr);
            check("tready", pix_tready, e_tr);
            if (tv && pix_tready) q.delete(0);
            else if (!tv && q.size() > 0) begin
                bt = q[0];
                bt.gap = 1'b0;
                q[0] = bt;
            end
            t++;
            @(negedge aclk);
            check_outputs();
        end
    endtask

    // entered on a negedge; leaves with reset released on a negedge
    task automatic do_reset();
        aresetn    = 1'b0;
        pix_tvalid = 1'b0;
        pix_tuser  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_hsync", hsync, 1'b1);
            check("rst_vsync", vsync, 1'b1);
            check("rst_rgb", {b, g, r}, '0);
            check("rst_de", de, 1'b0);
            check("rst_pulses", {sof, underflow, frame_err}, 3'b000);
            check("rst_tready", pix_tready, 1'b1);
            @(negedge aclk);
        end
        aresetn  = 1'b1;
        t        = 0;
        locked   = 0;
        holding  = 0;
        blank    = 0;
        seeded   = 0;
        start_at = $urandom_range(5, 100);
        q.delete();
    endtask

    initial begin
        @(negedge aclk);
        do_reset();
        run_cycles(1600);
        // land the second reset somewhere inside a frame
        run_cycles($urandom_range(1, 120));
        do_reset();
        run_cycles(1400);
`ifdef VGA_TEST_PATTERN_EN
        tp = 1'b1;
        run_cycles(300);
        tp = 1'b0;
        run_cycles(400);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
